// File: rtl/ansi_key_pkg.sv
// Shared key-event types, byte constants and final-byte decode helpers
// for the ANSI terminal key decoder.
package ansi_key_pkg;

   localparam int unsigned DEF_ESC_TIMEOUT = 4;
   localparam int unsigned DEF_MAX_CSI_LEN = 8;
   localparam int unsigned LEN_W           = 4;
   localparam int unsigned PARAM_W         = 8;
   localparam int unsigned BYTE_W          = 8;

   localparam logic [BYTE_W-1:0] BYTE_ESC    = 8'h1B;
   localparam logic [BYTE_W-1:0] BYTE_LBRACK = 8'h5B;
   localparam logic [BYTE_W-1:0] BYTE_SS3_O  = 8'h4F;
   localparam logic [BYTE_W-1:0] BYTE_TILDE  = 8'h7E;
   localparam logic [BYTE_W-1:0] BYTE_SEMI   = 8'h3B;
   localparam logic [BYTE_W-1:0] BYTE_NUL    = 8'h00;
   localparam logic [BYTE_W-1:0] BYTE_EOF    = 8'hFF;

   typedef enum logic [3:0] {
      KEY_NONE    = 4'd0,
      KEY_CHAR    = 4'd1,
      KEY_UP      = 4'd2,
      KEY_DOWN    = 4'd3,
      KEY_RIGHT   = 4'd4,
      KEY_LEFT    = 4'd5,
      KEY_HOME    = 4'd6,
      KEY_END     = 4'd7,
      KEY_INSERT  = 4'd8,
      KEY_DELETE  = 4'd9,
      KEY_PGUP    = 4'd10,
      KEY_PGDN    = 4'd11,
      KEY_ESC     = 4'd12,
      KEY_UNKNOWN = 4'd13
   } key_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ESC  = 2'd1,
      ST_CSI  = 2'd2,
      ST_SS3  = 2'd3
   } dec_state_e;

   typedef struct packed {
      key_code_e         code;
      logic [BYTE_W-1:0] ch;
      logic [2:0]        mod;
   } key_event_t;

   function automatic key_event_t mk_event(input key_code_e code,
                                           input logic [BYTE_W-1:0] ch,
                                           input logic [2:0] mod);
      key_event_t ev;
      ev.code = code;
      ev.ch   = ch;
      ev.mod  = mod;
      return ev;
   endfunction

   // Letter finals shared by CSI and SS3 sequences.
   function automatic key_code_e final_key(input logic [BYTE_W-1:0] b);
      case (b)
         8'h41:   return KEY_UP;
         8'h42:   return KEY_DOWN;
         8'h43:   return KEY_RIGHT;
         8'h44:   return KEY_LEFT;
         8'h48:   return KEY_HOME;
         8'h46:   return KEY_END;
         default: return KEY_UNKNOWN;
      endcase
   endfunction

   function automatic key_code_e tilde_key(input logic [PARAM_W-1:0] p0);
      case (p0)
         8'd1, 8'd7: return KEY_HOME;
         8'd2:       return KEY_INSERT;
         8'd3:       return KEY_DELETE;
         8'd4, 8'd8: return KEY_END;
         8'd5:       return KEY_PGUP;
         8'd6:       return KEY_PGDN;
         default:    return KEY_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/ansi_key_decoder_if.sv
// Byte-in / key-event-out bundle between the stdin reader and the game controller.
interface ansi_key_decoder_if;
   import ansi_key_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_byte;
   logic              key_valid;
   key_code_e         key_code;
   logic [BYTE_W-1:0] key_char;
   logic [2:0]        key_mod;

   modport master (output in_valid, in_byte,
                   input  key_valid, key_code, key_char, key_mod);
   modport slave  (input  in_valid, in_byte,
                   output key_valid, key_code, key_char, key_mod);
endinterface

// File: rtl/csi_param_acc.sv
// Decimal CSI parameter accumulator: value = value*10 + digit, saturating at 255.
module csi_param_acc
   import ansi_key_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_en,
   input  logic [3:0]         i_digit,
   output logic [PARAM_W-1:0] o_val
);

   logic [PARAM_W-1:0] r_val;
   logic [11:0]        w_sum;

   assign w_sum = 12'(r_val) * 12'd10 + 12'(i_digit);
   assign o_val = r_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_val <= '0;
      end else if (i_clr) begin
         r_val <= '0;
      end else if (i_en) begin
         r_val <= (w_sum > 12'd255) ? 8'd255 : w_sum[PARAM_W-1:0];
      end
   end

endmodule

// File: rtl/ansi_key_decoder.sv
// Turns the raw stdin byte stream into one key event per keypress, resolving
// ESC, CSI and SS3 sequences with an idle timeout.
module ansi_key_decoder
   import ansi_key_pkg::*;
#(
   parameter int unsigned ESC_TIMEOUT = DEF_ESC_TIMEOUT,
   parameter int unsigned MAX_CSI_LEN = DEF_MAX_CSI_LEN
) (
   input logic               clk,
   input logic               rst,
   ansi_key_decoder_if.slave kbd
);

   localparam int unsigned TMR_W = $clog2(ESC_TIMEOUT + 1);

   dec_state_e         r_state;
   logic [TMR_W-1:0]   r_timer;
   logic [LEN_W-1:0]   r_len;
   logic               r_semi;
   logic               r_key_valid;
   key_event_t         r_evt;

   logic [BYTE_W-1:0]  w_byte;
   logic [PARAM_W-1:0] w_p0;
   logic [PARAM_W-1:0] w_p1;
   logic [LEN_W-1:0]   w_len_inc;
   logic               w_is_drop;
   logic               w_dropped;
   logic               w_tmo;
   logic               w_is_digit;
   logic               w_in_range;
   logic               w_is_final;
   logic               w_len_over;
   logic               w_csi_acc;
   logic               w_acc_clr;
   key_code_e          w_csi_code;
   logic [2:0]         w_csi_mod;

   assign w_byte     = kbd.in_byte;
   assign w_is_drop  = (w_byte == BYTE_NUL) || (w_byte == BYTE_EOF);
   assign w_dropped  = kbd.in_valid && w_is_drop &&
                       ((r_state == ST_IDLE) || (r_state == ST_ESC));
   assign w_tmo      = !kbd.in_valid && (r_state != ST_IDLE) &&
                       (r_timer == TMR_W'(ESC_TIMEOUT - 1));
   assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
   assign w_in_range = (w_byte >= 8'h20) && (w_byte <= 8'h7E);
   assign w_is_final = (w_byte >= 8'h40);
   assign w_len_inc  = (r_len == '1) ? r_len : r_len + LEN_W'(1);
   assign w_len_over = 32'(w_len_inc) > MAX_CSI_LEN;

   // Digits go to p0 until the first ';', then to p1.
   assign w_csi_acc  = kbd.in_valid && (r_state == ST_CSI) && w_is_digit;
   assign w_acc_clr  = kbd.in_valid && (r_state == ST_ESC) && (w_byte == BYTE_LBRACK);
   assign w_csi_code = (w_byte == BYTE_TILDE) ? tilde_key(w_p0) : final_key(w_byte);
   assign w_csi_mod  = ((w_p1 >= 8'd2) && (w_p1 <= 8'd8)) ? 3'(w_p1 - 8'd1) : 3'd0;

   csi_param_acc u_p0 (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_acc_clr),
      .i_en    (w_csi_acc && !r_semi),
      .i_digit (w_byte[3:0]),
      .o_val   (w_p0)
   );

   csi_param_acc u_p1 (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_acc_clr),
      .i_en    (w_csi_acc && r_semi),
      .i_digit (w_byte[3:0]),
      .o_val   (w_p1)
   );

   assign kbd.key_valid = r_key_valid;
   assign kbd.key_code  = r_evt.code;
   assign kbd.key_char  = r_evt.ch;
   assign kbd.key_mod   = r_evt.mod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_len       <= '0;
         r_semi      <= 1'b0;
         r_key_valid <= 1'b0;
         r_evt       <= '0;
      end else begin
         r_key_valid <= 1'b0;

         // Dropped bytes inside ESC leave the timer running.
         if (kbd.in_valid) begin
            if (!w_dropped) r_timer <= '0;
         end else if (r_state != ST_IDLE) begin
            r_timer <= w_tmo ? '0 : r_timer + TMR_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (kbd.in_valid && !w_is_drop) begin
                  if (w_byte == BYTE_ESC) begin
                     r_state <= ST_ESC;
                  end else begin
                     r_key_valid <= 1'b1;
                     r_evt       <= mk_event(KEY_CHAR, w_byte, 3'b000);
                  end
               end
            end

            ST_ESC: begin
               if (kbd.in_valid) begin
                  if (w_byte == BYTE_LBRACK) begin
                     r_state <= ST_CSI;
                     r_len   <= '0;
                     r_semi  <= 1'b0;
                  end else if (w_byte == BYTE_SS3_O) begin
                     r_state <= ST_SS3;
                  end else if (w_byte == BYTE_ESC) begin
                     r_key_valid <= 1'b1;
                     r_evt       <= mk_event(KEY_ESC, 8'h00, 3'b000);
                  end else if (!w_is_drop) begin
                     r_key_valid <= 1'b1;
                     r_evt       <= mk_event(KEY_CHAR, w_byte, 3'b010);
                     r_state     <= ST_IDLE;
                  end
               end else if (w_tmo) begin
                  r_key_valid <= 1'b1;
                  r_evt       <= mk_event(KEY_ESC, 8'h00, 3'b000);
                  r_state     <= ST_IDLE;
               end
            end

            ST_CSI: begin
               if (kbd.in_valid) begin
                  if (!w_in_range) begin
                     r_key_valid <= 1'b1;
                     r_evt       <= mk_event(KEY_UNKNOWN, 8'h00, 3'b000);
                     r_state     <= (w_byte == BYTE_ESC) ? ST_ESC : ST_IDLE;
                  end else if (w_len_over) begin
                     r_key_valid <= 1'b1;
                     r_evt       <= mk_event(KEY_UNKNOWN, 8'h00, 3'b000);
                     r_state     <= ST_IDLE;
                  end else if (w_is_final) begin
                     r_key_valid <= 1'b1;
                     r_evt       <= mk_event(w_csi_code, 8'h00, w_csi_mod);
                     r_state     <= ST_IDLE;
                  end else begin
                     r_len <= w_len_inc;
                     if (w_byte == BYTE_SEMI) r_semi <= 1'b1;
                  end
               end else if (w_tmo) begin
                  r_key_valid <= 1'b1;
                  r_evt       <= mk_event(KEY_UNKNOWN, 8'h00, 3'b000);
                  r_state     <= ST_IDLE;
               end
            end

            ST_SS3: begin
               if (kbd.in_valid) begin
                  r_key_valid <= 1'b1;
                  r_evt       <= mk_event(final_key(w_byte), 8'h00, 3'b000);
                  r_state     <= (w_byte == BYTE_ESC) ? ST_ESC : ST_IDLE;
               end else if (w_tmo) begin
                  r_key_valid <= 1'b1;
                  r_evt       <= mk_event(KEY_UNKNOWN, 8'h00, 3'b000);
                  r_state     <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ansi_key_decoder.sv
// Self-checking bench: keypresses are generated as whole tokens whose expected
// event (code, char, mod, cycle) is known up front and compared in order.
module tb_ansi_key_decoder;
   import ansi_key_pkg::*;

   logic clk = 1'b0;
   logic rst;
   ansi_key_decoder_if kbd();

   ansi_key_decoder dut (
      .clk (clk),
      .rst (rst),
      .kbd (kbd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  code;
      logic [7:0]  ch;
      logic [2:0]  mod;
      logic [31:0] cyc;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] cyc   = 0;
   logic [7:0]  letters [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h46};

   always @(posedge clk) cyc <= cyc + 32'd1;

   always @(negedge clk)
      if (kbd.key_valid === 1'b1)
         obs_q.push_back({4'(kbd.key_code), kbd.key_char, kbd.key_mod, cyc});

   // Key-code numbering straight from the key table.
   function automatic logic [3:0] letter_code(input logic [7:0] f);
      case (f)
         8'h41:   return 4'd2;
         8'h42:   return 4'd3;
         8'h43:   return 4'd4;
         8'h44:   return 4'd5;
         8'h48:   return 4'd6;
         8'h46:   return 4'd7;
         default: return 4'd13;
      endcase
   endfunction

   function automatic logic [3:0] tilde_code(input int n);
      case (n)
         1, 7:    return 4'd6;
         2:       return 4'd8;
         3:       return 4'd9;
         4, 8:    return 4'd7;
         5:       return 4'd10;
         6:       return 4'd11;
         default: return 4'd13;
      endcase
   endfunction

   task automatic step(input logic v, input logic [7:0] b);
      kbd.in_valid = v;
      kbd.in_byte  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      step(1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic put_g(input logic [7:0] b, input int g);
      if (g > 0) idle(int'($urandom_range(0, g)));
      put(b);
   endtask

   task automatic send_bytes(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) put(v[8*i +: 8]);
   endtask

   task automatic expect_ev(input logic [3:0] c, input logic [7:0] ch, input logic [2:0] m);
      exp_q.push_back({c, ch, m, cyc});
   endtask

   task automatic tok_char();
      logic [7:0] b;
      b = 8'($urandom_range(1, 254));
      if (b == 8'h1B) b = 8'h1C;
      put(b);
      expect_ev(4'd1, b, 3'b000);
   endtask

   task automatic tok_alt(input int g);
      logic [7:0] b;
      b = 8'($urandom_range(32, 126));
      if (b == 8'h5B || b == 8'h4F) b = 8'h61;
      put(8'h1B);
      put_g(b, g);
      expect_ev(4'd1, b, 3'b010);
   endtask

   task automatic tok_esc();
      put(8'h1B);
      idle(4);
      expect_ev(4'd12, 8'h00, 3'b000);
   endtask

   task automatic tok_ss3(input int g);
      logic [7:0] fin;
      fin = ($urandom_range(0, 4) == 0) ? 8'h5A : letters[$urandom_range(0, 5)];
      put(8'h1B);
      put_g(8'h4F, g);
      put_g(fin, g);
      expect_ev(letter_code(fin), 8'h00, 3'b000);
   endtask

   task automatic tok_csi(input int g);
      logic [7:0] bq[$];
      logic [7:0] fin;
      int         p0, p1, nd, d;
      p0 = 0;
      p1 = 0;
      if ($urandom_range(0, 1) == 1) begin
         p0 = int'($urandom_range(1, 8));
         bq.push_back(8'(8'h30 + p0));
      end else begin
         nd = int'($urandom_range(0, 3));
         for (int i = 0; i < nd; i++) begin
            d  = int'($urandom_range(0, 9));
            p0 = p0 * 10 + d;
            bq.push_back(8'(8'h30 + d));
         end
      end
      if ($urandom_range(0, 1) == 1) begin
         bq.push_back(8'h3B);
         p1 = int'($urandom_range(0, 10));
         if (p1 == 10) begin
            bq.push_back(8'h31);
            bq.push_back(8'h30);
         end else begin
            bq.push_back(8'(8'h30 + p1));
         end
      end
      case ($urandom_range(0, 4))
         0, 1:    fin = 8'h7E;
         2, 3:    fin = letters[$urandom_range(0, 5)];
         default: fin = 8'h71;
      endcase
      put(8'h1B);
      put_g(8'h5B, g);
      foreach (bq[i]) put_g(bq[i], g);
      put_g(fin, g);
      expect_ev((fin == 8'h7E) ? tilde_code((p0 > 255) ? 255 : p0) : letter_code(fin),
                8'h00, (p1 >= 2 && p1 <= 8) ? 3'(p1 - 1) : 3'd0);
   endtask

   task automatic tok_any(input int g);
      case ($urandom_range(0, 4))
         0:       tok_char();
         1:       tok_alt(g);
         2:       tok_esc();
         3:       tok_ss3(g);
         default: tok_csi(g);
      endcase
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      kbd.in_valid = 1'b0;
      kbd.in_byte  = 8'h00;
      idle(3);
      n_chk++;
      if (kbd.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", kbd.key_valid); end
      n_chk++;
      if (kbd.key_code !== KEY_NONE) begin n_err++; $display("FAIL reset_code got %0d want 0", kbd.key_code); end
      n_chk++;
      if (kbd.key_char !== 8'h00) begin n_err++; $display("FAIL reset_char got %h want 00", kbd.key_char); end
      n_chk++;
      if (kbd.key_mod !== 3'b000) begin n_err++; $display("FAIL reset_mod got %b want 000", kbd.key_mod); end
      rst = 1'b0;
      idle(2);
      obs_q.delete();
   endtask

   task automatic test_chars();
      ev_t o, e;
      put(8'h20); expect_ev(4'd1, 8'h20, 3'b000);
      put(8'h00);
      put(8'h71); expect_ev(4'd1, 8'h71, 3'b000);
      put(8'hFF);
      idle(3);
      n_chk++;
      if (kbd.key_char !== 8'h71 || kbd.key_valid !== 1'b0) begin
         n_err++;
         $display("FAIL chars_hold got char=%h valid=%b want char=71 valid=0", kbd.key_char, kbd.key_valid);
      end
      for (int i = 0; i < 20; i++) begin
         tok_char();
         if ($urandom_range(0, 3) == 0) put(($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00);
      end
      idle(2);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL chars_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
         if (o !== e) begin n_err++; $display("FAIL chars_event got code=%0d char=%h mod=%b cyc=%0d want code=%0d char=%h mod=%b cyc=%0d", o.code, o.ch, o.mod, o.cyc, e.code, e.ch, e.mod, e.cyc); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_csi_ss3();
      ev_t o, e;
      send_bytes(64'h1B5B41, 3);         expect_ev(4'd2, 8'h00, 3'b000);
      send_bytes(64'h1B5B313B3543, 6);   expect_ev(4'd4, 8'h00, 3'b100);
      send_bytes(64'h1B4F46, 3);         expect_ev(4'd7, 8'h00, 3'b000);
      send_bytes(64'h1B5B337E, 4);       expect_ev(4'd9, 8'h00, 3'b000);
      send_bytes(64'h1B5B3939397E, 6);   expect_ev(4'd13, 8'h00, 3'b000);
      send_bytes(64'h1B5B367E, 4);       expect_ev(4'd11, 8'h00, 3'b000);
      send_bytes(64'h1B5B353B397E, 6);   expect_ev(4'd10, 8'h00, 3'b000);
      send_bytes(64'h1B5B313B3248, 6);   expect_ev(4'd6, 8'h00, 3'b001);
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0) tok_ss3(3); else tok_csi(3);
         idle(int'($urandom_range(0, 2)));
      end
      idle(2);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL csi_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
         if (o !== e) begin n_err++; $display("FAIL csi_event got code=%0d char=%h mod=%b cyc=%0d want code=%0d char=%h mod=%b cyc=%0d", o.code, o.ch, o.mod, o.cyc, e.code, e.ch, e.mod, e.cyc); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_esc();
      ev_t o, e;
      put(8'h1B); idle(4);          expect_ev(4'd12, 8'h00, 3'b000);
      send_bytes(64'h1B1B, 2);      expect_ev(4'd12, 8'h00, 3'b000);
      idle(4);                      expect_ev(4'd12, 8'h00, 3'b000);
      send_bytes(64'h1B61, 2);      expect_ev(4'd1, 8'h61, 3'b010);
      put(8'h1B); idle(3); put(8'h62); expect_ev(4'd1, 8'h62, 3'b010);
      put(8'h1B); idle(3); put(8'h5B); idle(3); put(8'h41); expect_ev(4'd2, 8'h00, 3'b000);
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 2) == 0) tok_esc(); else tok_alt(3);
      end
      idle(2);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL esc_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
         if (o !== e) begin n_err++; $display("FAIL esc_event got code=%0d char=%h mod=%b cyc=%0d want code=%0d char=%h mod=%b cyc=%0d", o.code, o.ch, o.mod, o.cyc, e.code, e.ch, e.mod, e.cyc); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_aborts();
      ev_t o, e;
      send_bytes(64'h1B5B, 2);
      for (int i = 0; i < 9; i++) put(8'h30);
      expect_ev(4'd13, 8'h00, 3'b000);
      send_bytes(64'h1B5B, 2);
      for (int i = 0; i < 7; i++) put(8'h30);
      put(8'h41);                        expect_ev(4'd2, 8'h00, 3'b000);
      send_bytes(64'h1B5B31, 3); put(8'h1B); expect_ev(4'd13, 8'h00, 3'b000);
      send_bytes(64'h5B42, 2);           expect_ev(4'd3, 8'h00, 3'b000);
      send_bytes(64'h1B5B31, 3); idle(4);  expect_ev(4'd13, 8'h00, 3'b000);
      send_bytes(64'h1B4F, 2); idle(4);    expect_ev(4'd13, 8'h00, 3'b000);
      send_bytes(64'h1B4F, 2); put(8'h1B); expect_ev(4'd13, 8'h00, 3'b000);
      idle(4);                           expect_ev(4'd12, 8'h00, 3'b000);
      send_bytes(64'h1B5B, 2); put(8'h00); expect_ev(4'd13, 8'h00, 3'b000);
      put(8'h41);                        expect_ev(4'd1, 8'h41, 3'b000);
      send_bytes(64'h1B5B3F327E, 5);     expect_ev(4'd8, 8'h00, 3'b000);
      send_bytes(64'h1B5B313B3B3341, 7); expect_ev(4'd2, 8'h00, 3'b010);
      send_bytes(64'h1B5B, 2); idle(3); put(8'h41); expect_ev(4'd2, 8'h00, 3'b000);
      idle(2);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
         if (o !== e) begin n_err++; $display("FAIL abort_event got code=%0d char=%h mod=%b cyc=%0d want code=%0d char=%h mod=%b cyc=%0d", o.code, o.ch, o.mod, o.cyc, e.code, e.ch, e.mod, e.cyc); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      ev_t o, e;
      for (int i = 0; i < 60; i++) begin
         tok_any(0);
         if ($urandom_range(0, 4) == 0) put(8'hFF);
      end
      idle(2);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
         if (o !== e) begin n_err++; $display("FAIL b2b_event got code=%0d char=%h mod=%b cyc=%0d want code=%0d char=%h mod=%b cyc=%0d", o.code, o.ch, o.mod, o.cyc, e.code, e.ch, e.mod, e.cyc); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      ev_t o, e;
      send_bytes(64'h1B5B31, 3);
      rst = 1'b1;
      idle(2);
      n_chk++;
      if (kbd.key_valid !== 1'b0 || kbd.key_code !== KEY_NONE) begin
         n_err++;
         $display("FAIL rstmid_outputs got valid=%b code=%0d want valid=0 code=0", kbd.key_valid, kbd.key_code);
      end
      rst = 1'b0;
      idle(6);
      put(8'h41); expect_ev(4'd1, 8'h41, 3'b000);
      idle(2);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
         if (o !== e) begin n_err++; $display("FAIL rstmid_event got code=%0d char=%h mod=%b cyc=%0d want code=%0d char=%h mod=%b cyc=%0d", o.code, o.ch, o.mod, o.cyc, e.code, e.ch, e.mod, e.cyc); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_chars();
      test_csi_ss3();
      test_esc();
      test_aborts();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ansi_key_decoder.md
# ansi_key_decoder

Decodes the raw terminal byte stream from the stdin reader into discrete key events: printable/control characters, Alt-prefixed characters, bare ESC, and ANSI CSI/SS3 cursor and editing keys (arrows, Home/End, Insert/Delete, PgUp/PgDn) with xterm modifiers. It is the input-side counterpart of the ANSI escape writer used by the view. It sits between the stdin reader and the game controller, so the controller consumes one event per keypress instead of raw bytes.

## Interface
- `ESC_TIMEOUT`, 4: idle cycles (no `in_valid`) after a pending ESC/CSI/SS3 byte before the sequence is resolved.
- `MAX_CSI_LEN`, 8: maximum bytes accepted after `ESC [` before the sequence aborts.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_byte` carries a new byte this cycle.
- `in_byte`  in  8  raw stdin byte.
- `key_valid`  out  1  one-cycle event strobe.
- `key_code`  out  4  event type (package enum).
- `key_char`  out  8  character for KEY_CHAR, else 0.
- `key_mod`  out  3  {ctrl, alt, shift}.

## Operation
- Key codes: NONE 0, CHAR 1, UP 2, DOWN 3, RIGHT 4, LEFT 5, HOME 6, END 7, INSERT 8, DELETE 9, PGUP 10, PGDN 11, ESC 12, UNKNOWN 13.
- States: IDLE, ESC, CSI, SS3. Exactly one event per accepted byte or per timeout, never two.
- IDLE: 0x00 and 0xFF are dropped (reader idle value / EOF). 0x1B -> ESC, no event. Any other byte -> CHAR, `key_char`=byte, mod 0.
- ESC: `[` -> CSI, with p0=p1=0 and len=0. `O` -> SS3. 0x1B -> emit ESC, stay in ESC, restart timer. 0x00/0xFF dropped, timer keeps running. Other byte -> CHAR with alt=1, then IDLE. Timeout -> emit ESC, then IDLE.
- CSI: digit -> active param = param*10+digit, saturating at 255. `;` -> switch to p1; a second `;` is ignored. Final byte 0x40–0x7E -> emit, then IDLE:
  - A/B/C/D -> UP/DOWN/RIGHT/LEFT; H -> HOME; F -> END.
  - `~` with p0 1/7 -> HOME, 2 -> INSERT, 3 -> DELETE, 4/8 -> END, 5 -> PGUP, 6 -> PGDN, else UNKNOWN.
  - Any other final -> UNKNOWN.
  - Modifier: if p1 is in 2..8, `key_mod`=p1-1 (bit0 shift, bit1 alt, bit2 ctrl); otherwise 0.
- CSI aborts:
  - Other 0x20–0x3F byte -> ignored but counted.
  - Byte outside 0x20–0x7E -> UNKNOWN; next state is ESC if the byte was 0x1B, else IDLE.
  - len exceeds MAX_CSI_LEN -> UNKNOWN, IDLE.
  - Timeout -> UNKNOWN, IDLE.
- SS3: A/B/C/D/H/F map as in CSI, mod 0. Other printable -> UNKNOWN. 0x1B -> UNKNOWN, then ESC. Timeout -> UNKNOWN. All exits go to IDLE unless stated.
- Width rules: params 8-bit saturating; len counter 4-bit saturating; timer counts to ESC_TIMEOUT.

## Timing
- Reset values: `key_valid`=0, `key_code`=0, `key_char`=0, `key_mod`=0; state IDLE; params, len and timer all 0.
- Latency: event outputs are registered; `key_valid` asserts the cycle after the deciding byte is accepted. Outputs hold their values until the next event; `key_valid` drops after one cycle.
- Timer: counts only in ESC/CSI/SS3 on cycles with `in_valid`=0, and is cleared by any accepted byte. The event fires on the cycle the count reaches ESC_TIMEOUT; `key_valid` is seen the following cycle.
- Simultaneous byte and expiry: the byte wins and the timer clears.
- Back-to-back bytes every cycle are supported; no backpressure.
- Reset mid-sequence discards the partial sequence; no event is emitted.

## Structure
- `ansi_key_pkg`: key-code constants, byte constants (ESC 8'h1B, LBRACK 8'h5B, SS3_O 8'h4F, TILDE 8'h7E, SEMI 8'h3B), state encodings.
- Sub-module `csi_param_acc`: decimal digit accumulator with 255 saturation and clear. It is instantiated twice, for p0 and p1.

## Test plan
- Bytes 0x20, 0x71 -> CHAR 0x20 then CHAR 0x71, each `key_valid` one cycle after its byte; 0x00/0xFF interleaved produce nothing.
- `1B 5B 41` -> UP, mod 0. `1B 5B 31 3B 35 43` -> RIGHT, mod 3'b100. `1B 4F 46` -> END.
- `1B 5B 33 7E` -> DELETE. `1B 5B 39 39 39 7E` -> UNKNOWN (p0 saturates at 255). `1B 5B 36 7E` -> PGDN.
- Lone 1B followed by 4 idle cycles -> ESC. `1B 1B` -> ESC, then ESC again after timeout. `1B 61` -> CHAR 0x61, alt=1.
- `1B 5B` + 9×`30` -> UNKNOWN at the 9th byte. `1B 5B 31 1B 5B 42` -> UNKNOWN then DOWN.
- Assert `rst` after `1B 5B 31`; release; send `41` -> CHAR 0x41 with no stale event.
